phi_edge_sched: RTL and testbench
=================================

// Module: phi_edge_sched
// PURPOSE
//  Round-robin scheduler for control-flow edges feeding a PHI-node data mux.
//  Arbitrates among NUM_EDGES predecessor edges, latches the winning edge's value and index
//  into one output register, and presents it downstream with a valid/ready handshake.
//  Sits between predecessor basic-block datapaths and the PHI consumer; the registered
//  edge index drives the mux select.
// PARAMETERS
//  NUM_EDGES   4   number of incoming edges, legal 1..16
//  DATA_W      32  width of each incoming value
//  IDX_W       $clog2(NUM_EDGES) (min 1)  width of edge index
// PORTS
//  clk           in   1                 clock; all logic on rising edge
//  rst_n         in   1                 reset, synchronous, active-low
//  enable        in   1                 0 = freeze: no grant, no state change, outputs held
//  edge_valid    in   NUM_EDGES         per-edge value present
//  edge_data     in   NUM_EDGES*DATA_W  edge i value at [i*DATA_W +: DATA_W]
//  edge_ready    out  NUM_EDGES         one-hot grant; edge i consumed when valid&ready
//  out_valid     out  1                 output register holds a value
//  out_data      out  DATA_W            selected value
//  out_edge_idx  out  IDX_W             index of edge that produced out_data
//  out_ready     in   1                 consumer accepts when out_valid&out_ready
//  conflict_cnt  out  16                saturating count of cycles with >=2 edges requesting at grant
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=EMPTY; out_valid=0; out_data=0; out_edge_idx=0;
//    rr_ptr=0; conflict_cnt=0; edge_ready=0 combinationally while rst_n=0.
//  State machine: EMPTY (register free), FULL (register holds unconsumed value).
//  can_load = enable & (state==EMPTY | out_ready).
//  edge_ready = can_load ? rr_grant(edge_valid, rr_ptr) : 0; at most one bit set.
//  rr_grant: first valid edge searching rr_ptr, rr_ptr+1, ... wrapping mod NUM_EDGES.
//  On grant to edge g: out_data<=edge_data[g], out_edge_idx<=g, out_valid<=1,
//    rr_ptr<=(g+1) mod NUM_EDGES (wraps NUM_EDGES-1 -> 0); state->FULL.
//  FULL & out_ready & no edge valid (enable=1): out_valid<=0, state->EMPTY.
//  FULL & out_ready & edge valid: drain and reload same cycle; state stays FULL (full throughput).
//  FULL & !out_ready: hold out_data/out_edge_idx stable; edge_ready=0.
//  enable=0: edge_ready=0, all registers hold, incl. a pending out_valid; output handshake
//    still not completed (drain suppressed) so stall is global.
//  Latency: edge handshake cycle N -> out_valid/out_data visible cycle N+1.
//  conflict_cnt increments by 1 on each grant cycle where popcount(edge_valid)>=2;
//    saturates at 16'hFFFF.
//  NUM_EDGES=1: rr_ptr constant 0; behaves as single-entry pipeline register.
//  Edges not granted must hold valid/data (standard valid/ready; no drop).
//  Reset mid-transfer: pending output discarded, no edge_ready asserted in reset cycle.
// TESTING
//  1. Reset: rst_n=0 with edge_valid=4'hF -> edge_ready=0, out_valid=0, conflict_cnt=0 next cycle.
//  2. Single edge: edge_valid=4'b0100, data2=32'hDEAD_BEEF, out_ready=1 -> edge_ready=4'b0100;
//     next cycle out_valid=1, out_data=DEADBEEF, out_edge_idx=2.
//  3. Round-robin: edge_valid=4'hF held, out_ready=1 for 8 cycles -> grant order
//     0,1,2,3,0,1,2,3; conflict_cnt=8.
//  4. Backpressure: out_ready=0 after one grant -> edge_ready=0, out_data stable 5 cycles;
//     out_ready=1 with edge 1 valid -> drain and reload same cycle, out_edge_idx=1.
//  5. enable=0 for 3 cycles while FULL and out_ready=1 -> no drain, no grant, all outputs held.
//  6. Saturation: force 70000 conflict grants -> conflict_cnt=16'hFFFF, stays there.

Source files
------------

// File: rtl/phi_edge_sched.sv
// Round-robin edge scheduler feeding a PHI-node mux: picks one valid predecessor
// edge, registers its value and index, and hands it downstream via valid/ready.
module phi_edge_sched #(
  parameter int NUM_EDGES = 4,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [NUM_EDGES-1:0]        edge_valid,
  input  logic [NUM_EDGES*DATA_W-1:0] edge_data,
  output logic [NUM_EDGES-1:0]        edge_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [IDX_W-1:0]            out_edge_idx,
  input  logic                        out_ready,
  output logic [15:0]                 conflict_cnt
);

  typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t                 state_r, state_nxt_s;
  logic                   out_valid_r;
  logic [DATA_W-1:0]      out_data_r;
  logic [IDX_W-1:0]       out_idx_r;
  logic [IDX_W-1:0]       rr_ptr_r;
  logic [15:0]            conflict_cnt_r;

  logic                   can_load_s;
  logic [NUM_EDGES-1:0]   grant_s;
  logic                   grant_any_s;
  logic [DATA_W-1:0]      sel_data_s;
  logic [IDX_W-1:0]       sel_idx_s;
  logic [IDX_W-1:0]       ptr_nxt_s;
  logic                   multi_req_s;

  function automatic logic [NUM_EDGES-1:0] first_set(input logic [NUM_EDGES-1:0] req);
    logic [NUM_EDGES-1:0] one;
    logic                 found;
    one   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_EDGES; i++) begin
      if (req[i] && !found) begin
        one[i] = 1'b1;
        found  = 1'b1;
      end else begin
        one[i] = 1'b0;
      end
    end
    return one;
  endfunction

  // Requests at or above the pointer win first; otherwise wrap to the lowest request.
  function automatic logic [NUM_EDGES-1:0] rr_grant(input logic [NUM_EDGES-1:0] valid,
                                                   input logic [IDX_W-1:0]     ptr);
    logic [NUM_EDGES-1:0] upper;
    upper = '0;
    for (int i = 0; i < NUM_EDGES; i++) begin
      upper[i] = valid[i] & (IDX_W'(i) >= ptr);
    end
    return (|upper) ? first_set(upper) : first_set(valid);
  endfunction

  function automatic logic [4:0] popcount(input logic [NUM_EDGES-1:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < NUM_EDGES; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return cnt;
  endfunction

  // Grant selection and winning-edge data/index mux.
  always_comb begin
    can_load_s = enable & ((state_r == ST_EMPTY) | out_ready);
    if (rst_n && can_load_s) begin
      grant_s = rr_grant(edge_valid, rr_ptr_r);
    end else begin
      grant_s = '0;
    end
    grant_any_s = |grant_s;
    sel_data_s  = '0;
    sel_idx_s   = '0;
    for (int i = 0; i < NUM_EDGES; i++) begin
      sel_data_s = sel_data_s | ({DATA_W{grant_s[i]}} & edge_data[i*DATA_W +: DATA_W]);
      sel_idx_s  = sel_idx_s  | ({IDX_W{grant_s[i]}} & IDX_W'(i));
    end
    if (sel_idx_s == IDX_W'(NUM_EDGES - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = sel_idx_s + IDX_W'(1);
    end
    multi_req_s = (popcount(edge_valid) >= 5'd2);
  end

  // Next-state logic for the single-entry output register.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (grant_any_s) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (grant_any_s) begin
          state_nxt_s = ST_FULL;
        end else if (enable && out_ready) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // State, output register, round-robin pointer and conflict counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= ST_EMPTY;
      out_valid_r    <= 1'b0;
      out_data_r     <= '0;
      out_idx_r      <= '0;
      rr_ptr_r       <= '0;
      conflict_cnt_r <= 16'd0;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= (state_nxt_s == ST_FULL);
      if (grant_any_s) begin
        out_data_r <= sel_data_s;
        out_idx_r  <= sel_idx_s;
        rr_ptr_r   <= ptr_nxt_s;
      end
      if (grant_any_s && multi_req_s && (conflict_cnt_r != 16'hFFFF)) begin
        conflict_cnt_r <= conflict_cnt_r + 16'd1;
      end
    end
  end

  assign edge_ready   = grant_s;
  assign out_valid    = out_valid_r;
  assign out_data     = out_data_r;
  assign out_edge_idx = out_idx_r;
  assign conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_phi_edge_sched.sv
// Self-checking bench for phi_edge_sched: a reference model predicts grants and
// queues expected output-register contents, popped as the consumer drains them.
module tb_phi_edge_sched;
  localparam int NE = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst_n, enable, out_ready, out_valid;
  logic [NE-1:0]    edge_valid, edge_ready;
  logic [NE*DW-1:0] edge_data;
  logic [DW-1:0]    out_data;
  logic [IW-1:0]    out_edge_idx;
  logic [15:0]      conflict_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { int idx; logic [DW-1:0] data; } exp_t;
  exp_t          exp_q[$];
  bit            m_full;
  int            m_ptr;
  int            m_cnt;
  logic [NE-1:0] exp_ready;

  phi_edge_sched #(.NUM_EDGES(NE), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .edge_valid(edge_valid),
    .edge_data(edge_data), .edge_ready(edge_ready), .out_valid(out_valid),
    .out_data(out_data), .out_edge_idx(out_edge_idx), .out_ready(out_ready),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_full = 1'b0; m_ptr = 0; m_cnt = 0;
    exp_q.delete();
  endtask

  // Advance the reference model by the cycle whose inputs are currently driven.
  task automatic model_step();
    int g;
    int pc;
    int p;
    bit can;
    g = -1; pc = 0;
    can = enable && (!m_full || out_ready);
    if (enable && m_full && out_ready) begin
      if (exp_q.size() > 0) exp_q.delete(0);
      m_full = 1'b0;
    end
    exp_ready = '0;
    if (can) begin
      for (int k = 0; k < NE; k++) begin
        p = (m_ptr + k) % NE;
        if (g < 0 && edge_valid[p]) g = p;
      end
    end
    if (g >= 0) begin
      for (int i = 0; i < NE; i++) pc += int'(edge_valid[i]);
      exp_ready[g] = 1'b1;
      exp_q.push_back('{idx: g, data: edge_data[g*DW +: DW]});
      m_ptr  = (g + 1) % NE;
      m_full = 1'b1;
      if (pc >= 2 && m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; edge_valid = '0; out_ready = 1'b0; enable = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; out_ready = 1'b1; edge_valid = 4'hF;
    for (int i = 0; i < NE; i++) edge_data[i*DW +: DW] = 32'hA000_0000 + i;
    #1;
    n_cmp++; if (edge_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", edge_ready); end
    @(posedge clk); @(negedge clk); #1;
    n_cmp++; if (edge_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready2: got %b want 0000", edge_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (conflict_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", conflict_cnt); end
    n_cmp++; if (out_data !== 32'd0 || out_edge_idx !== 2'd0) begin n_err++; $display("FAIL reset_data: got %h/%0d want 0/0", out_data, out_edge_idx); end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1; edge_valid = '0;
  endtask

  task automatic test_single_edge();
    @(negedge clk);
    edge_valid = 4'b0100; edge_data[2*DW +: DW] = 32'hDEAD_BEEF; out_ready = 1'b1; #1;
    model_step();
    n_cmp++; if (edge_ready !== 4'b0100 || edge_ready !== exp_ready) begin n_err++; $display("FAIL single_ready: got %b want 0100", edge_ready); end
    @(negedge clk);
    edge_valid = '0; #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || out_edge_idx !== 2'd2) begin n_err++; $display("FAIL single_out: got v%b %h idx%0d want v1 deadbeef idx2", out_valid, out_data, out_edge_idx); end
    n_cmp++; if (out_data !== exp_q[0].data) begin n_err++; $display("FAIL single_sb: got %h want %h", out_data, exp_q[0].data); end
    model_step();
    @(negedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got v%b want v0", out_valid); end
  endtask

  task automatic test_round_robin();
    logic [NE-1:0] ord;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      edge_valid = 4'hF; out_ready = 1'b1; enable = 1'b1; #1;
      if (c > 0) begin
        n_cmp++; if (out_valid !== 1'b1 || int'(out_edge_idx) !== exp_q[0].idx) begin n_err++; $display("FAIL rr_out c%0d: got v%b idx%0d want v1 idx%0d", c, out_valid, out_edge_idx, exp_q[0].idx); end
      end
      model_step();
      ord = 4'b0001 << (c % 4);
      n_cmp++; if (edge_ready !== ord || edge_ready !== exp_ready) begin n_err++; $display("FAIL rr_grant c%0d: got %b want %b", c, edge_ready, ord); end
    end
    @(negedge clk);
    edge_valid = '0; #1;
    n_cmp++; if (conflict_cnt !== 16'd8 || conflict_cnt !== 16'(m_cnt)) begin n_err++; $display("FAIL rr_cnt: got %0d want 8", conflict_cnt); end
    model_step();
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    edge_valid = 4'b0001; out_ready = 1'b1; #1;
    model_step();
    n_cmp++; if (edge_ready !== 4'b0001) begin n_err++; $display("FAIL bp_first: got %b want 0001", edge_ready); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      edge_valid = 4'hF; out_ready = 1'b0; #1;
      model_step();
      n_cmp++; if (edge_ready !== 4'b0000 || edge_ready !== exp_ready) begin n_err++; $display("FAIL bp_ready c%0d: got %b want 0000", c, edge_ready); end
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hA000_0000 || out_edge_idx !== 2'd0) begin n_err++; $display("FAIL bp_hold c%0d: got v%b %h idx%0d want v1 a0000000 idx0", c, out_valid, out_data, out_edge_idx); end
    end
    @(negedge clk);
    edge_valid = 4'b0010; out_ready = 1'b1; #1;
    model_step();
    n_cmp++; if (edge_ready !== 4'b0010) begin n_err++; $display("FAIL bp_reload: got %b want 0010", edge_ready); end
    @(negedge clk);
    edge_valid = '0; out_ready = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b1 || out_edge_idx !== 2'd1 || out_data !== exp_q[0].data) begin n_err++; $display("FAIL bp_after: got v%b idx%0d %h want v1 idx1 %h", out_valid, out_edge_idx, out_data, exp_q[0].data); end
    model_step();
  endtask

  task automatic test_enable();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      enable = 1'b0; out_ready = 1'b1; edge_valid = 4'hF; #1;
      model_step();
      n_cmp++; if (edge_ready !== 4'b0000) begin n_err++; $display("FAIL en_ready c%0d: got %b want 0000", c, edge_ready); end
      n_cmp++; if (out_valid !== 1'b1 || out_edge_idx !== 2'd1 || conflict_cnt !== 16'(m_cnt)) begin n_err++; $display("FAIL en_hold c%0d: got v%b idx%0d cnt%0d want v1 idx1 cnt%0d", c, out_valid, out_edge_idx, conflict_cnt, m_cnt); end
    end
    @(negedge clk);
    enable = 1'b1; edge_valid = '0; out_ready = 1'b1; #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_q[0].data) begin n_err++; $display("FAIL en_after: got v%b %h want v1 %h", out_valid, out_data, exp_q[0].data); end
    model_step();
    @(negedge clk);
    out_ready = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL en_drain: got v%b want v0", out_valid); end
    model_step();
  endtask

  task automatic test_random();
    logic [NE-1:0] last_g;
    last_g = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int i = 0; i < NE; i++) begin
        if (!edge_valid[i] || last_g[i]) begin
          edge_valid[i] = 1'($urandom_range(0, 1));
          edge_data[i*DW +: DW] = $urandom;
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 7) != 0);
      #1;
      n_cmp++; if (out_valid !== m_full) begin n_err++; $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid, m_full); end
      if (m_full) begin
        n_cmp++; if (out_data !== exp_q[0].data || int'(out_edge_idx) !== exp_q[0].idx) begin n_err++; $display("FAIL rnd_data c%0d: got %h/%0d want %h/%0d", c, out_data, out_edge_idx, exp_q[0].data, exp_q[0].idx); end
      end
      n_cmp++; if (conflict_cnt !== 16'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, conflict_cnt, m_cnt); end
      model_step();
      n_cmp++; if (edge_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", c, edge_ready, exp_ready); end
      last_g = exp_ready;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    enable = 1'b1; out_ready = 1'b0; edge_valid = 4'b0001; #1;
    model_step();
    @(negedge clk);
    rst_n = 1'b0; edge_valid = 4'hF; out_ready = 1'b1; #1;
    n_cmp++; if (edge_ready !== 4'b0000 || out_valid !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b v%b want 0000 v1", edge_ready, out_valid); end
    model_clear();
    @(negedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || conflict_cnt !== 16'd0) begin n_err++; $display("FAIL mid_clear: got v%b cnt%0d want v0 cnt0", out_valid, conflict_cnt); end
    rst_n = 1'b1; edge_valid = '0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 70000; c++) begin
      @(negedge clk);
      edge_valid = 4'hF; out_ready = 1'b1; enable = 1'b1; #1;
      model_step();
    end
    @(negedge clk);
    edge_valid = 4'hF; #1;
    n_cmp++; if (conflict_cnt !== 16'hFFFF || m_cnt != 65535) begin n_err++; $display("FAIL sat_cnt: got %h want ffff", conflict_cnt); end
    model_step();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      model_step();
    end
    @(negedge clk); #1;
    n_cmp++; if (conflict_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h want ffff", conflict_cnt); end
    n_cmp++; if (out_valid !== 1'b1 || int'(out_edge_idx) !== exp_q[0].idx) begin n_err++; $display("FAIL sat_out: got v%b idx%0d want v1 idx%0d", out_valid, out_edge_idx, exp_q[0].idx); end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_round_robin();
    test_backpressure();
    test_enable();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
